// File: rtl/pwm_duty_ctrl_if.sv
// Sample/command and duty/status bundle between the loop supervisor and pwm_duty_ctrl.
interface pwm_duty_ctrl_if #(
  parameter int ADC_WIDTH = 12,
  parameter int BIT_WIDTH = 21
);
  logic                 run;
  logic [ADC_WIDTH-1:0] vref;
  logic                 sample_valid;
  logic [ADC_WIDTH-1:0] sample;
  logic [BIT_WIDTH-1:0] duty;
  logic                 enable;
  logic                 duty_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output run, vref, sample_valid, sample,
    input  duty, enable, duty_valid, busy, overrun
  );

  modport slave (
    input  run, vref, sample_valid, sample,
    output duty, enable, duty_valid, busy, overrun
  );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// Closed-loop PI duty generator with soft-started reference and integrator anti-windup,
// feeding the complementary PWM bridge one sample at a time.
module pwm_duty_ctrl #(
  parameter int BIT_WIDTH = 21,
  parameter int ADC_WIDTH = 12,
  parameter int FRAC_BITS = 4,
  parameter int KP        = 16,
  parameter int KI        = 2,
  parameter int DUTY_MIN  = 20,
  parameter int DUTY_MAX  = 180,
  parameter int SS_STEP   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_duty_ctrl_if.slave bus
);

  localparam int ACC_W = 40;
  localparam int ERR_W = ADC_WIDTH + 1;

  localparam logic signed [ACC_W-1:0] KP_S   = ACC_W'(KP);
  localparam logic signed [ACC_W-1:0] KI_S   = ACC_W'(KI);
  localparam logic signed [ACC_W-1:0] DMIN_S = ACC_W'(DUTY_MIN);
  localparam logic signed [ACC_W-1:0] DMAX_S = ACC_W'(DUTY_MAX);
  localparam logic signed [ACC_W-1:0] IMIN_S = ACC_W'(DUTY_MIN) <<< FRAC_BITS;
  localparam logic signed [ACC_W-1:0] IMAX_S = ACC_W'(DUTY_MAX) <<< FRAC_BITS;
  localparam logic [BIT_WIDTH-1:0]    DUTY_RST = BIT_WIDTH'(DUTY_MIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR  = 2'd1,
    S_MULT = 2'd2,
    S_ACC  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic accept_s;
  logic drop_s;
  logic ld_err_s;
  logic ld_mult_s;
  logic ld_acc_s;
  logic busy_d;

  logic [ADC_WIDTH-1:0]      sample_q;
  logic [ADC_WIDTH-1:0]      ref_ss_q, ref_ss_d;
  logic [31:0]               ss_sum_s;
  logic signed [ERR_W-1:0]   e_q, e_d;
  logic signed [ACC_W-1:0]   e_ext_s;
  logic signed [ACC_W-1:0]   p_q, p_d;
  logic signed [ACC_W-1:0]   i_q, i_d;
  logic signed [ACC_W-1:0]   integ_q, integ_d;
  logic signed [ACC_W-1:0]   integ_sum_s;
  logic signed [ACC_W-1:0]   u_s;
  logic signed [ACC_W-1:0]   duty_c_s;
  logic [BIT_WIDTH-1:0]      duty_q, duty_d;
  logic                      enable_q;
  logic                      duty_valid_q;
  logic                      busy_q;
  logic                      overrun_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: fixed three-cycle pipeline, abandoned whenever run drops
  always_comb begin
    state_d = state_q;
    if (!bus.run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.sample_valid) begin
            state_d = S_ERR;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ERR:   state_d = S_MULT;
        S_MULT:  state_d = S_ACC;
        S_ACC:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: per-stage load strobes and sample accept/drop decisions
  always_comb begin
    accept_s  = 1'b0;
    drop_s    = 1'b0;
    ld_err_s  = 1'b0;
    ld_mult_s = 1'b0;
    ld_acc_s  = 1'b0;
    busy_d    = (state_d != S_IDLE);
    if (bus.run) begin
      accept_s  = (state_q == S_IDLE) && bus.sample_valid;
      drop_s    = (state_q != S_IDLE) && bus.sample_valid;
      ld_err_s  = (state_q == S_ERR);
      ld_mult_s = (state_q == S_MULT);
      ld_acc_s  = (state_q == S_ACC);
    end else begin
      accept_s  = 1'b0;
    end
  end

  // Datapath: soft-start reference, error, gains, clamped integrator and duty
  always_comb begin
    ss_sum_s = 32'(ref_ss_q) + 32'(SS_STEP);
    // Snap to vref on reaching it, and also when vref has dropped below the ramp.
    if ((ss_sum_s >= 32'(bus.vref)) || (ref_ss_q > bus.vref)) begin
      ref_ss_d = bus.vref;
    end else begin
      ref_ss_d = ADC_WIDTH'(ss_sum_s);
    end

    e_d     = $signed({1'b0, ref_ss_q}) - $signed({1'b0, sample_q});
    e_ext_s = {{(ACC_W-ERR_W){e_q[ERR_W-1]}}, e_q};
    p_d     = e_ext_s * KP_S;
    i_d     = e_ext_s * KI_S;

    integ_sum_s = integ_q + i_q;
    if (integ_sum_s < IMIN_S) begin
      integ_d = IMIN_S;
    end else if (integ_sum_s > IMAX_S) begin
      integ_d = IMAX_S;
    end else begin
      integ_d = integ_sum_s;
    end

    u_s = (p_q + integ_d) >>> FRAC_BITS;
    if (u_s < DMIN_S) begin
      duty_c_s = DMIN_S;
    end else if (u_s > DMAX_S) begin
      duty_c_s = DMAX_S;
    end else begin
      duty_c_s = u_s;
    end
    duty_d = BIT_WIDTH'(duty_c_s);
  end

  // Pipeline and output registers; run low clears the loop state on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q     <= '0;
      ref_ss_q     <= '0;
      e_q          <= '0;
      p_q          <= '0;
      i_q          <= '0;
      integ_q      <= IMIN_S;
      duty_q       <= DUTY_RST;
      enable_q     <= 1'b0;
      duty_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      duty_valid_q <= ld_acc_s;
      if (!bus.run) begin
        ref_ss_q  <= '0;
        integ_q   <= IMIN_S;
        duty_q    <= DUTY_RST;
        enable_q  <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        if (accept_s) begin
          sample_q <= bus.sample;
          ref_ss_q <= ref_ss_d;
        end
        if (drop_s) begin
          overrun_q <= 1'b1;
        end
        if (ld_err_s) begin
          e_q <= e_d;
        end
        if (ld_mult_s) begin
          p_q <= p_d;
          i_q <= i_d;
        end
        if (ld_acc_s) begin
          integ_q  <= integ_d;
          duty_q   <= duty_d;
          enable_q <= 1'b1;
        end
      end
    end
  end

  assign bus.duty       = duty_q;
  assign bus.enable     = enable_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Closed-loop duty generator directly upstream of the complementary PWM bridge. It takes ADC samples of the controlled voltage and runs a soft-started reference and a fixed-point PI law with anti-windup, one sample at a time. Its `duty` and `enable` outputs wire straight into the bridge's `duty` and `enable` inputs, with the same `BIT_WIDTH`. It produces a clamped duty word and a bridge enable.

## Interface
- `BIT_WIDTH`, 21: duty word width; must equal the bridge's.
- `ADC_WIDTH`, 12: unsigned sample/reference width.
- `FRAC_BITS`, 4: fractional bits of gains and integrator.
- `KP`, 16: proportional gain, unsigned 16-bit, scaled by 2^FRAC_BITS.
- `KI`, 2: integral gain per sample, unsigned 16-bit, scaled by 2^FRAC_BITS.
- `DUTY_MIN`, 20: lower duty clamp; must be ≥ bridge deadtime.
- `DUTY_MAX`, 180: upper duty clamp; must be ≤ bridge half_period − deadtime.
- `SS_STEP`, 1: soft-start reference increment per accepted sample.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: level; 1 = regulate, 0 = stop.
- `vref` in ADC_WIDTH: target reference, unsigned; may change at any time.
- `sample_valid` in 1: one-cycle strobe; `sample` is valid in this cycle.
- `sample` in ADC_WIDTH: measured voltage, unsigned.
- `duty` out BIT_WIDTH: duty word to the bridge.
- `enable` out 1: bridge enable.
- `duty_valid` out 1: one-cycle pulse when `duty` updates.
- `busy` out 1: compute in flight; samples are not accepted.
- `overrun` out 1: sticky; a sample was dropped.

## Operation
- FSM states: IDLE, ERR, MULT, ACC.
  - IDLE → ERR on `run & sample_valid`.
  - ERR → MULT → ACC → IDLE unconditionally.
  - Any state → IDLE when `run`=0.
- Accept in IDLE:
  - Register `sample`.
  - Update `ref_ss`: if `ref_ss + SS_STEP ≥ vref`, or `ref_ss > vref`, then `ref_ss ← vref`; otherwise `ref_ss ← ref_ss + SS_STEP`.
  - The new `ref_ss` is the value used for this sample.
- ERR: `e = ref_ss − sample`, signed, ADC_WIDTH+1 bits.
- MULT: register `p = KP·e` and `i = KI·e`. Signed, 40-bit internal; no overflow is possible at the defaults.
- ACC:
  - `integ_n = integ + i`, clamped to [DUTY_MIN·2^FRAC_BITS, DUTY_MAX·2^FRAC_BITS] (anti-windup).
  - `u = (p + integ_n) >>> FRAC_BITS`, arithmetic shift, floor.
  - `duty ← clamp(u, DUTY_MIN, DUTY_MAX)`; `integ ← integ_n`; `duty_valid` pulses.
- `enable`:
  - Set to 1 by the first `duty_valid` after `run` rises.
  - Held at 1 while `run`=1.
- `sample_valid` while not in IDLE: the sample is dropped and `overrun ← 1`. `overrun` clears only when `run`=0.
- `sample_valid` while `run`=0: ignored; no overrun.
- `run`=0 for any cycle, on the next edge:
  - `enable←0`, `duty←DUTY_MIN`, `integ←DUTY_MIN·2^FRAC_BITS`.
  - `ref_ss←0`, `overrun←0`, FSM←IDLE.
  - Any in-flight result is discarded, with no `duty_valid`.
- `vref` drops below `ref_ss`: `ref_ss` snaps to `vref` on the next accepted sample.

## Timing
- Reset values:
  - `duty`=DUTY_MIN; `enable`, `duty_valid`, `busy`, `overrun`=0.
  - `integ`=DUTY_MIN·2^FRAC_BITS; `ref_ss`=0; FSM IDLE.
- Sample accepted in cycle T:
  - `busy`=1 in T+1..T+3.
  - `duty` holds its new value and `duty_valid`=1 in T+4.
  - `enable` rises in T+4 for the first result after `run` rises.
- FSM is IDLE in T+4, so a sample at T+4 is accepted. Minimum sample spacing is 4 cycles; samples at T+1..T+3 set `overrun`.
- `duty` is stable between `duty_valid` pulses. The bridge consumes it asynchronously to its own counter.
- `run` falls in cycle T: `enable`=0 and `duty`=DUTY_MIN from T+1.
- `rst_n` assertion clears all state immediately, mid-computation included.

## Test plan
- Reset, then `run`=1, SS_STEP=4096, `vref`=100, `sample`=90 strobed once at T → `duty`=31, `duty_valid` at T+4, `enable` rises at T+4, `integ`=340.
- Saturation: `vref`=4000, `sample`=0, repeated every 4 cycles → `duty`=180 every update, `integ` pinned at 2880. Then `sample`=4095, `vref`=0 → `duty`=20 on the first update, with no windup delay.
- Soft-start: SS_STEP=1, `vref`=50, 60 samples at 8-cycle spacing → `ref_ss`=1,2,…,50, then stays at 50. Lower `vref` to 30 → next sample uses 30.
- Overrun: strobes at T and T+2 → one `duty_valid` at T+4 and `overrun`=1. A strobe at T+4 is accepted. `run`=0 clears `overrun`.
- `run` dropped at T+2 of a compute → no `duty_valid`, `enable`=0 and `duty`=20 at T+3. A strobe while `run`=0 gives no response.
- `rst_n` pulsed low mid-compute → all outputs return to reset values asynchronously, and operation resumes from soft-start.
